// File: rtl/uart_cmd_wrapper.sv
// ---------------------------------------------------------------------------
// uart_cmd_wrapper
//   Command-side serial front end. Receives 8N1 UART bytes on RX, pairs them
//   (high byte first, then low byte) into a 16-bit command, and serializes a
//   single response byte back out on TX.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   RX           serial input, idles high, asynchronous to clk
//   TX           serial output, idles high
//   cmd[15:0]    assembled command {high byte, low byte}
//   cmd_rdy      command valid, held until clr_cmd_rdy or next high byte
//   clr_cmd_rdy  consumer acknowledge, clears cmd_rdy
//   resp[7:0]    response byte to transmit
//   trmt         one-cycle pulse starting transmission of resp
//   tx_done      set when the stop bit completes, held until next trmt
//
// Parameters
//   BAUD_CLKS     clocks per bit period (>= 16)
//   TIMEOUT_CLKS  inter-byte timeout in clocks
//
// Build option
//   CMD_TIMEOUT_EN  when defined, an assembly that sits with only the high
//                   byte for TIMEOUT_CLKS clocks drops it and waits for a
//                   fresh high byte. When undefined, it waits indefinitely.
// ---------------------------------------------------------------------------
module uart_cmd_wrapper #(
    parameter int unsigned BAUD_CLKS    = 5208,
    parameter int unsigned TIMEOUT_CLKS = 1 << 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int unsigned   BW        = $clog2(BAUD_CLKS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CLKS - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_CLKS / 2 - 1);

    // -----------------------------------------------------------------------
    // RX synchronizer: two metastability flops plus one edge-detect flop,
    // all preset high so reset never looks like a start bit.
    // -----------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    // -----------------------------------------------------------------------
    // RX FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     rx_state_q;
    logic [BW-1:0] rx_baud_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_byte_q;
    logic          rx_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_rdy_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                        rx_baud_q  <= '0;
                    end
                end
                RX_START: begin
                    // Mid-start-bit re-check rejects short glitches.
                    if (rx_baud_q == HALF_LAST) begin
                        rx_baud_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud_q <= rx_baud_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud_q == BAUD_LAST) begin
                        rx_baud_q  <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 4'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        rx_baud_q <= rx_baud_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_baud_q == BAUD_LAST) begin
                        rx_baud_q  <= '0;
                        rx_state_q <= RX_IDLE;
                        // A low stop bit is a framing error: byte dropped.
                        if (rx_sync_q) begin
                            rx_rdy_q  <= 1'b1;
                            rx_byte_q <= rx_shift_q;
                        end
                    end else begin
                        rx_baud_q <= rx_baud_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Command assembly
    // -----------------------------------------------------------------------
    typedef enum logic {A_WAIT_HI, A_WAIT_LO} asm_state_e;

    asm_state_e asm_state_q;
    logic [7:0] hi_q;
    logic [15:0] cmd_q;
    logic       cmd_rdy_q;
    logic       to_expire;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned   TW      = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic [TW-1:0] to_cnt_q;

    assign to_expire = (asm_state_q == A_WAIT_LO) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (rx_rdy_q || (asm_state_q != A_WAIT_LO) || to_expire) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state_q <= A_WAIT_HI;
            hi_q        <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
        end else if (rx_rdy_q) begin
            // Byte acceptance takes priority over clr_cmd_rdy so a command
            // completing in the same cycle as an acknowledge is not lost.
            if (asm_state_q == A_WAIT_HI) begin
                hi_q        <= rx_byte_q;
                cmd_rdy_q   <= 1'b0;
                asm_state_q <= A_WAIT_LO;
            end else begin
                cmd_q       <= {hi_q, rx_byte_q};
                cmd_rdy_q   <= 1'b1;
                asm_state_q <= A_WAIT_HI;
            end
        end else begin
            if (clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
            if (to_expire) begin
                asm_state_q <= A_WAIT_HI;
            end
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

    // -----------------------------------------------------------------------
    // TX FSM. The shift register back-fills with ones, so its LSB is the
    // line level both while idle and during the frame.
    // -----------------------------------------------------------------------
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_e;

    tx_state_e     tx_state_q;
    logic [9:0]    tx_shift_q;
    logic [BW-1:0] tx_baud_q;
    logic [3:0]    tx_bit_q;
    logic          tx_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_shift_q <= {1'b1, resp, 1'b0};
                        tx_done_q  <= 1'b0;
                        tx_baud_q  <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_baud_q == BAUD_LAST) begin
                        tx_baud_q  <= '0;
                        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                        tx_bit_q   <= tx_bit_q + 1'b1;
                        if (tx_bit_q == 4'd9) begin
                            tx_state_q <= TX_IDLE;
                            tx_done_q  <= 1'b1;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
module tb_uart_cmd_wrapper;

    localparam int B  = 16;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    uart_cmd_wrapper #(.BAUD_CLKS(B), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .trmt(trmt), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes accepted so far that have not yet formed a pair.
    logic [7:0]  acc_q[$];
    logic [15:0] exp_cmd = '0;
    logic        exp_rdy = 1'b0;

    bit clr_watch   = 1'b0;
    bit watch_hit   = 1'b0;
    bit chk_tx_idle = 1'b0;

    task automatic model_byte(input logic [7:0] b);
        acc_q.push_back(b);
        if (acc_q.size() == 1) begin
            exp_rdy = 1'b0;
        end else begin
            exp_cmd = {acc_q[0], acc_q[1]};
            exp_rdy = 1'b1;
            acc_q.delete();
        end
    endtask

    task automatic model_reset();
        acc_q.delete();
        exp_cmd = '0;
        exp_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            RX = 1'b1;
        end
    endtask

    // Drives one full 8N1 frame, one clock at a time.
    task automatic send_byte(input logic [7:0] b, input bit stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int n = 0; n < 10 * B; n++) begin
            @(negedge clk);
            RX = fr[n / B];
            if (clr_watch && cmd_rdy) begin
                clr_cmd_rdy = 1'b0;
                clr_watch   = 1'b0;
                watch_hit   = 1'b1;
            end
            if (chk_tx_idle) begin
                checks++;
                if (TX !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_idle got %b exp 1", TX);
                end
            end
        end
    endtask

    task automatic send_and_check(input logic [7:0] b, input string nm);
        send_byte(b, 1'b1);
        model_byte(b);
        idle(2);
        checks++;
        if (cmd_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL %s cmd_rdy got %b exp %b", nm, cmd_rdy, exp_rdy);
        end
        checks++;
        if (cmd !== exp_cmd) begin
            errors++;
            $display("FAIL %s cmd got %h exp %h", nm, cmd, exp_cmd);
        end
    endtask

    // Sends resp=r and checks TX level and tx_done on every clock of the
    // frame; bit j of the frame is 0 (start), r[j-1] (data) or 1 (stop).
    task automatic do_tx_frame(input logic [7:0] r, input bit retrig);
        logic exp_tx, exp_done;
        int   j;
        @(negedge clk);
        resp = r;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        resp = 8'($urandom);
        for (int n = 0; n <= 10 * B; n++) begin
            j = n / B;
            if (n < 10 * B) begin
                exp_tx   = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : r[j-1];
                exp_done = 1'b0;
            end else begin
                exp_tx   = 1'b1;
                exp_done = 1'b1;
            end
            checks++;
            if (TX !== exp_tx) begin
                errors++;
                $display("FAIL tx_bit n=%0d got %b exp %b", n, TX, exp_tx);
            end
            checks++;
            if (tx_done !== exp_done) begin
                errors++;
                $display("FAIL tx_done n=%0d got %b exp %b", n, tx_done, exp_done);
            end
            if (retrig && n == 5 * B) begin
                resp = ~r;
                trmt = 1'b1;
            end else begin
                trmt = 1'b0;
            end
            if (n < 10 * B) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", TX); end
            checks++;
            if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd got %h exp 0000", cmd); end
            checks++;
            if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", cmd_rdy); end
            checks++;
            if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", tx_done); end
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        model_reset();
    endtask

    task automatic test_cmd_random();
        logic [7:0] h, l;
        for (int k = 0; k < 6; k++) begin
            h = (k == 0) ? 8'h4B : 8'($urandom);
            l = (k == 0) ? 8'hF1 : 8'($urandom);
            send_and_check(h, "rand_hi");
            send_and_check(l, "rand_lo");
            idle($urandom_range(0, 20));
        end
    endtask

    task automatic test_clr();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        checks++;
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL clr_rdy got %b exp 0", cmd_rdy); end
        checks++;
        if (cmd !== exp_cmd) begin errors++; $display("FAIL clr_cmd got %h exp %h", cmd, exp_cmd); end
        // Acknowledge held across low-byte acceptance: the new command wins.
        send_and_check(8'($urandom), "setwin_hi");
        clr_cmd_rdy = 1'b1;
        clr_watch   = 1'b1;
        watch_hit   = 1'b0;
        send_and_check(8'($urandom), "setwin_lo");
        clr_cmd_rdy = 1'b0;
        clr_watch   = 1'b0;
        checks++;
        if (watch_hit !== 1'b1) begin errors++; $display("FAIL setwin_seen got %b exp 1", watch_hit); end
    endtask

    task automatic test_tx();
        do_tx_frame(8'hA5, 1'b1);
        idle(3);
        do_tx_frame(8'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] h, l, r;
        h = 8'($urandom); l = 8'($urandom); r = 8'($urandom);
        fork
            begin
                send_byte(h, 1'b1);
                send_byte(l, 1'b1);
            end
            do_tx_frame(r, 1'b0);
        join
        model_byte(h);
        model_byte(l);
        idle(2);
        checks++;
        if (cmd !== exp_cmd) begin errors++; $display("FAIL b2b_cmd got %h exp %h", cmd, exp_cmd); end
        checks++;
        if (cmd_rdy !== exp_rdy) begin errors++; $display("FAIL b2b_rdy got %b exp %b", cmd_rdy, exp_rdy); end
    endtask

    task automatic test_framing();
        send_byte(8'h57, 1'b0);
        idle(2 * B);
        checks++;
        if (cmd !== exp_cmd) begin errors++; $display("FAIL frame_cmd got %h exp %h", cmd, exp_cmd); end
        send_and_check(8'h57, "frame_hi");
        send_and_check(8'hF2, "frame_lo");
    endtask

    task automatic test_glitch();
        repeat (3) begin
            @(negedge clk);
            RX = 1'b0;
        end
        idle(3 * B);
        checks++;
        if (cmd_rdy !== exp_rdy) begin errors++; $display("FAIL glitch_rdy got %b exp %b", cmd_rdy, exp_rdy); end
        send_and_check(8'($urandom), "glitch_hi");
        send_and_check(8'($urandom), "glitch_lo");
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr;
        send_and_check(8'h40, "rmid_hi");
        fr = {1'b1, 8'h99, 1'b0};
        for (int n = 0; n < 5 * B; n++) begin
            @(negedge clk);
            RX = fr[n / B];
        end
        #2;
        rst_n = 1'b0;
        RX    = 1'b1;
        model_reset();
        #1;
        checks++;
        if (cmd !== 16'h0000) begin errors++; $display("FAIL rmid_cmd got %h exp 0000", cmd); end
        checks++;
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rmid_rdy got %b exp 0", cmd_rdy); end
        checks++;
        if (tx_done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", tx_done); end
        checks++;
        if (TX !== 1'b1) begin errors++; $display("FAIL rmid_tx got %b exp 1", TX); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk_tx_idle = 1'b1;
        send_and_check(8'h06, "rmid_06");
        send_and_check(8'h00, "rmid_00");
        chk_tx_idle = 1'b0;
        checks++;
        if (cmd !== 16'h0600) begin errors++; $display("FAIL rmid_final got %h exp 0600", cmd); end
    endtask

    task automatic test_timeout();
        send_and_check(8'h4B, "to_hi");
        idle(1200);
`ifdef CMD_TIMEOUT_EN
        // A lone high byte older than the timeout is discarded.
        acc_q.delete();
`endif
        send_and_check(8'h57, "to_57");
        send_and_check(8'hF2, "to_F2");
    endtask

    initial begin
        test_reset();
        test_cmd_random();
        test_clr();
        test_tx();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_timeout();
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
